// File: rtl/sha256_pad_io_adapter_if.sv
// Signal bundle between the pad ring / SHA-256 core and the pad I/O adapter.
// The slave modport is the adapter's view; master is the pad ring and core side.
interface sha256_pad_io_adapter_if #(
  parameter int unsigned PAD_W = 8
);
  logic [PAD_W-1:0] pad_data;
  logic             pad_write_enable;
  logic             pad_first_block;
  logic             pad_last_block;
  logic             pad_busy;
  logic [PAD_W-1:0] pad_digest;
  logic             pad_output_enable;
  logic             digest_overflow;
  logic [31:0]      core_data;
  logic             core_write_enable;
  logic             core_first_block;
  logic             core_last_block;
  logic             core_busy;
  logic [31:0]      core_digest;
  logic             core_output_enable;

  modport master (
    output pad_data, pad_write_enable, pad_first_block, pad_last_block,
    output core_busy, core_digest, core_output_enable,
    input  pad_busy, pad_digest, pad_output_enable, digest_overflow,
    input  core_data, core_write_enable, core_first_block, core_last_block
  );

  modport slave (
    input  pad_data, pad_write_enable, pad_first_block, pad_last_block,
    input  core_busy, core_digest, core_output_enable,
    output pad_busy, pad_digest, pad_output_enable, digest_overflow,
    output core_data, core_write_enable, core_first_block, core_last_block
  );
endinterface

// File: rtl/sha256_pad_io_adapter.sv
// Narrow-pad to 32-bit word adapter for the SHA-256 core: inbound beat assembly + word FIFO,
// outbound digest capture buffer re-serialised MSB-first onto the digest pads.
module sha256_pad_io_adapter #(
  parameter int unsigned PAD_W        = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DIGEST_WORDS = 8
) (
  input logic                    clk,
  input logic                    reset,
  sha256_pad_io_adapter_if.slave io_bus
);
  localparam int unsigned BEATS = 32 / PAD_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned WW    = $clog2(DIGEST_WORDS);
  localparam int unsigned CW    = $clog2(DIGEST_WORDS + 1);

  typedef logic [BW-1:0] beat_t;
  typedef logic [AW:0]   fcnt_t;
  typedef logic [WW-1:0] widx_t;
  typedef logic [CW-1:0] dcnt_t;
  typedef enum logic {DIdle, DSend} dstate_e;

  logic [31:0]           r_asm;
  beat_t                 r_beat;
  logic                  r_asm_first, r_asm_last;
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_first, r_fifo_last;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  fcnt_t                 r_count;
  logic [31:0]           r_core_data;
  logic                  r_core_we, r_core_first, r_core_last;

  dstate_e               r_state;
  logic [31:0]           r_dbuf [DIGEST_WORDS];
  dcnt_t                 r_cap_cnt;
  widx_t                 r_sword;
  beat_t                 r_sbeat;
  logic [PAD_W-1:0]      r_pad_digest;
  logic                  r_pad_oe, r_overflow;

  logic                  w_busy, w_beat_acc, w_final, w_push, w_pop;
  logic [31:0]           w_word;
  logic                  w_word_first, w_word_last;
  logic                  w_cap_ok, w_last_beat, w_done;
  widx_t                 w_cap_idx, w_src_word;
  beat_t                 w_src_beat;
  logic [31:0]           w_src_val;
  logic [PAD_W-1:0]      w_src_slice;

  assign w_busy     = (r_count == fcnt_t'(FIFO_DEPTH));
  assign w_beat_acc = io_bus.pad_write_enable && !w_busy;
  assign w_final    = (r_beat == beat_t'(BEATS - 1));
  assign w_push     = w_beat_acc && w_final;
  assign w_pop      = (r_count != '0) && !io_bus.core_busy && (r_state == DIdle);

  // Word as it will look once the current beat lands; the final beat pushes this directly.
  always_comb begin
    w_word = r_asm;
    w_word[(BEATS - 1 - int'(r_beat)) * PAD_W +: PAD_W] = io_bus.pad_data;
    w_word_first = (r_beat == '0) ? io_bus.pad_first_block : r_asm_first;
    w_word_last  = (r_beat == '0) ? io_bus.pad_last_block : r_asm_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm        <= '0;
      r_beat       <= '0;
      r_asm_first  <= 1'b0;
      r_asm_last   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_core_data  <= '0;
      r_core_we    <= 1'b0;
      r_core_first <= 1'b0;
      r_core_last  <= 1'b0;
    end else begin
      if (w_beat_acc) begin
        r_asm       <= w_word;
        r_asm_first <= w_word_first;
        r_asm_last  <= w_word_last;
        r_beat      <= w_final ? '0 : r_beat + 1'b1;
      end
      if (w_push) begin
        r_fifo_data[r_wr_ptr]  <= w_word;
        r_fifo_first[r_wr_ptr] <= w_word_first;
        r_fifo_last[r_wr_ptr]  <= w_word_last;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
      end
      r_core_we <= w_pop;
      if (w_pop) begin
        r_core_data  <= r_fifo_data[r_rd_ptr];
        r_core_first <= r_fifo_first[r_rd_ptr];
        r_core_last  <= r_fifo_last[r_rd_ptr];
        r_rd_ptr     <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign w_cap_ok    = io_bus.core_output_enable && (r_cap_cnt != dcnt_t'(DIGEST_WORDS));
  assign w_cap_idx   = r_cap_cnt[WW-1:0];
  assign w_last_beat = (r_sbeat == beat_t'(BEATS - 1));
  assign w_done      = w_last_beat && (r_sword == widx_t'(DIGEST_WORDS - 1));

  // Beat presented after this edge; bypass the buffer when that entry is captured this edge.
  always_comb begin
    w_src_word = '0;
    w_src_beat = '0;
    if (r_state == DSend) begin
      if (w_last_beat) begin
        w_src_word = r_sword + 1'b1;
      end else begin
        w_src_word = r_sword;
        w_src_beat = r_sbeat + 1'b1;
      end
    end
    w_src_val   = (w_cap_ok && (w_cap_idx == w_src_word)) ? io_bus.core_digest
                                                          : r_dbuf[w_src_word];
    w_src_slice = w_src_val[(BEATS - 1 - int'(w_src_beat)) * PAD_W +: PAD_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= DIdle;
      r_cap_cnt    <= '0;
      r_sword      <= '0;
      r_sbeat      <= '0;
      r_pad_digest <= '0;
      r_pad_oe     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_cap_ok) begin
        r_dbuf[w_cap_idx] <= io_bus.core_digest;
        r_cap_cnt         <= r_cap_cnt + 1'b1;
      end else if (io_bus.core_output_enable) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        DIdle: begin
          if (w_cap_ok) begin
            r_state      <= DSend;
            r_sword      <= w_src_word;
            r_sbeat      <= w_src_beat;
            r_pad_oe     <= 1'b1;
            r_pad_digest <= w_src_slice;
          end
        end
        DSend: begin
          if (w_done) begin
            r_state      <= DIdle;
            r_cap_cnt    <= '0;
            r_sword      <= '0;
            r_sbeat      <= '0;
            r_pad_oe     <= 1'b0;
            r_pad_digest <= '0;
          end else begin
            r_sword      <= w_src_word;
            r_sbeat      <= w_src_beat;
            r_pad_digest <= w_src_slice;
          end
        end
        default: r_state <= DIdle;
      endcase
    end
  end

  assign io_bus.pad_busy          = w_busy;
  assign io_bus.pad_digest        = r_pad_digest;
  assign io_bus.pad_output_enable = r_pad_oe;
  assign io_bus.digest_overflow   = r_overflow;
  assign io_bus.core_data         = r_core_data;
  assign io_bus.core_write_enable = r_core_we;
  assign io_bus.core_first_block  = r_core_first;
  assign io_bus.core_last_block   = r_core_last;
endmodule

// File: tb/tb_sha256_pad_io_adapter.sv
// Self-checking bench for sha256_pad_io_adapter: PAD_W=8 and PAD_W=32 instances, vector table,
// hand-written corner sequences and randomized traffic against a queue/arithmetic reference.
module tb_sha256_pad_io_adapter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha256_pad_io_adapter_if #(.PAD_W(8))  b8 ();
  sha256_pad_io_adapter_if #(.PAD_W(32)) b32 ();

  sha256_pad_io_adapter #(.PAD_W(8), .FIFO_DEPTH(4), .DIGEST_WORDS(8)) dut8 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (b8)
  );

  sha256_pad_io_adapter #(.PAD_W(32), .FIFO_DEPTH(4), .DIGEST_WORDS(8)) dut32 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (b32)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic        first, last;
    logic [31:0] exp_data;
    logic        exp_first, exp_last;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] dw [9];
  logic [31:0] fw [5];
  logic [31:0] rw [12];
  logic        rf [12];
  logic        rl [12];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b8.pad_data = '0;  b8.pad_write_enable = 1'b0;  b8.pad_first_block = 1'b0;
    b8.pad_last_block = 1'b0;  b8.core_busy = 1'b0;  b8.core_digest = '0;
    b8.core_output_enable = 1'b0;
    b32.pad_data = '0; b32.pad_write_enable = 1'b0; b32.pad_first_block = 1'b0;
    b32.pad_last_block = 1'b0; b32.core_busy = 1'b0; b32.core_digest = '0;
    b32.core_output_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Capture ncap digest words (one every k cycles) on the 8-bit DUT, inject one inbound word
  // meanwhile, and compare the serialised pad stream with the expected MSB-first byte list.
  task automatic run_digest8(input int ncap, input int k, input logic exp_ovf, input string tag);
    logic [7:0]  got [$];
    logic [31:0] inj, sdata;
    logic [7:0]  exp_b;
    logic        prev_oe;
    int          first_hi, last_hi, n_hi, fall, strobes, stall_bad, idx;
    inj = $urandom; sdata = '0; prev_oe = 1'b0;
    first_hi = -1; last_hi = -1; n_hi = 0; fall = -1; strobes = 0; stall_bad = 0;
    for (int c = 0; c < 400; c++) begin
      idx = c / k;
      b8.core_output_enable = ((c % k) == 0) && (idx < ncap);
      b8.core_digest = b8.core_output_enable ? dw[idx] : $urandom;
      b8.pad_write_enable = (c >= 2) && (c < 6);
      b8.pad_data = b8.pad_write_enable ? 8'((inj >> (24 - 8 * (c - 2))) & 32'hff) : 8'h00;
      b8.pad_first_block = (c == 2);
      tick();
      if (b8.pad_output_enable) begin
        got.push_back(b8.pad_digest);
        n_hi++;
        if (first_hi < 0) first_hi = c;
        last_hi = c;
      end else if (first_hi >= 0 && fall < 0) begin
        fall = c;
      end
      if (b8.core_write_enable) begin
        strobes++;
        sdata = b8.core_data;
        if (prev_oe) stall_bad++;
      end
      prev_oe = b8.pad_output_enable;
      if (fall >= 0 && c >= fall + 5) break;
    end
    idle_inputs();
    chk({tag, "_first_cycle"}, 32'(first_hi), 32'd0);
    chk({tag, "_oe_cycles"}, 32'(n_hi), 32'd32);
    chk({tag, "_contiguous"}, 32'(last_hi - first_hi + 1), 32'd32);
    chk({tag, "_oe_dropped"}, 32'(fall >= 0), 32'd1);
    for (int i = 0; i < 32; i++) begin
      exp_b = 8'((dw[i / 4] >> (24 - 8 * (i % 4))) & 32'hff);
      if (i < got.size()) chk($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_b));
    end
    chk({tag, "_fwd_stall"}, 32'(stall_bad), 32'd0);
    chk({tag, "_fwd_count"}, 32'(strobes), 32'd1);
    chk({tag, "_fwd_data"}, sdata, inj);
    chk({tag, "_overflow"}, 32'(b8.digest_overflow), 32'(exp_ovf));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          strobes, rx, wi, bi, n_hi, first_hi, last_hi;
    logic        drive, accepted;
    logic [31:0] got32 [$];
    int          gidx [$];

    reset = 1'b1;
    idle_inputs();
    vecs[0] = '{8'h61, 8'h62, 8'h63, 8'h80, 1'b1, 1'b0, 32'h61626380, 1'b1, 1'b0};
    vecs[1] = '{8'hde, 8'had, 8'hbe, 8'hef, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'hff, 8'h00, 8'hff, 1'b1, 1'b1, 32'h00ff00ff, 1'b1, 1'b1};
    vecs[3] = '{8'ha5, 8'h5a, 8'hc3, 8'h3c, 1'b0, 1'b0, 32'ha55ac33c, 1'b0, 1'b0};
    do_reset();

    chk("rst_pad_busy", 32'(b8.pad_busy), 32'd0);
    chk("rst_pad_digest", 32'(b8.pad_digest), 32'd0);
    chk("rst_pad_oe", 32'(b8.pad_output_enable), 32'd0);
    chk("rst_overflow", 32'(b8.digest_overflow), 32'd0);
    chk("rst_core_data", b8.core_data, 32'd0);
    chk("rst_core_we", 32'(b8.core_write_enable), 32'd0);
    chk("rst_core_first", 32'(b8.core_first_block), 32'd0);
    chk("rst_core_last", 32'(b8.core_last_block), 32'd0);
    chk("rst32_pad_oe", 32'(b32.pad_output_enable), 32'd0);

    // Table: flags driven inverted on beats 1..3 to show they come from beat 0 only.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] bs [4];
      bs[0] = vecs[i].b0; bs[1] = vecs[i].b1; bs[2] = vecs[i].b2; bs[3] = vecs[i].b3;
      for (int b = 0; b < 4; b++) begin
        b8.pad_write_enable = 1'b1;
        b8.pad_data = bs[b];
        b8.pad_first_block = (b == 0) ? vecs[i].first : ~vecs[i].first;
        b8.pad_last_block  = (b == 0) ? vecs[i].last  : ~vecs[i].last;
        tick();
      end
      idle_inputs();
      chk($sformatf("vec%0d_we_early", i), 32'(b8.core_write_enable), 32'd0);
      tick();
      chk($sformatf("vec%0d_we", i), 32'(b8.core_write_enable), 32'd1);
      chk($sformatf("vec%0d_data", i), b8.core_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_first", i), 32'(b8.core_first_block), 32'(vecs[i].exp_first));
      chk($sformatf("vec%0d_last", i), 32'(b8.core_last_block), 32'(vecs[i].exp_last));
      tick();
      chk($sformatf("vec%0d_we_once", i), 32'(b8.core_write_enable), 32'd0);
    end

    // FIFO full with a busy core; the fifth word must be ignored.
    fw[0] = 32'h11111111; fw[1] = 32'h22222222; fw[2] = 32'h33333333;
    fw[3] = 32'h44444444; fw[4] = 32'h55555555;
    b8.core_busy = 1'b1;
    strobes = 0;
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        b8.pad_write_enable = 1'b1;
        b8.pad_data = 8'((fw[w] >> (24 - 8 * b)) & 32'hff);
        tick();
        if (b8.core_write_enable) strobes++;
      end
      if (w == 3) chk("full_busy_after4", 32'(b8.pad_busy), 32'd1);
    end
    chk("full_busy_after5", 32'(b8.pad_busy), 32'd1);
    chk("full_no_strobe_busy", 32'(strobes), 32'd0);
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) chk("full_busy_release", 32'(b8.pad_busy), 32'd0);
      if (b8.core_write_enable) begin
        got32.push_back(b8.core_data);
        gidx.push_back(c);
      end
    end
    chk("full_strobe_count", 32'(got32.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < got32.size()) begin
        chk($sformatf("full_word%0d", j), got32[j], fw[j]);
        chk($sformatf("full_cycle%0d", j), 32'(gidx[j]), 32'(j));
      end
    end

    // Reset in the middle of a word discards the partial beats.
    b8.pad_write_enable = 1'b1;
    b8.pad_data = 8'h11; tick();
    b8.pad_data = 8'h22; tick();
    b8.pad_write_enable = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    fw[0] = 32'hdeadbeef;
    for (int b = 0; b < 4; b++) begin
      b8.pad_write_enable = 1'b1;
      b8.pad_data = 8'((fw[0] >> (24 - 8 * b)) & 32'hff);
      tick();
    end
    idle_inputs();
    tick();
    chk("rstmid_we", 32'(b8.core_write_enable), 32'd1);
    chk("rstmid_data", b8.core_data, 32'hdeadbeef);
    tick();

    // SHA-256("abc") digest, then random digests with spaced captures.
    dw[0] = 32'hba7816bf; dw[1] = 32'h8f01cfea; dw[2] = 32'h414140de; dw[3] = 32'h5dae2223;
    dw[4] = 32'hb00361a3; dw[5] = 32'h96177a9c; dw[6] = 32'hb410ff61; dw[7] = 32'hf20015ad;
    dw[8] = 32'h0badf00d;
    run_digest8(8, 1, 1'b0, "abc");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) dw[i] = $urandom;
      run_digest8(8, int'($urandom_range(1, 4)), 1'b0, $sformatf("rnddig%0d", r));
    end

    // Nine back-to-back captures: eight serialised, overflow sticky until reset.
    for (int i = 0; i < 9; i++) dw[i] = $urandom;
    run_digest8(9, 1, 1'b1, "ovf");
    tick(); tick(); tick();
    chk("ovf_sticky", 32'(b8.digest_overflow), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(b8.digest_overflow), 32'd0);

    // Reset during a digest drain.
    for (int c = 0; c < 6; c++) begin
      b8.core_output_enable = 1'b1;
      b8.core_digest = $urandom;
      tick();
    end
    idle_inputs();
    chk("dsend_active", 32'(b8.pad_output_enable), 32'd1);
    reset = 1'b1;
    tick();
    chk("dsend_rst_oe", 32'(b8.pad_output_enable), 32'd0);
    chk("dsend_rst_digest", 32'(b8.pad_digest), 32'd0);
    reset = 1'b0;
    tick(); tick();
    chk("dsend_after_rst_oe", 32'(b8.pad_output_enable), 32'd0);

    // PAD_W=32: single-beat words and one digest word per output cycle.
    b32.pad_write_enable = 1'b1;
    b32.pad_data = 32'h12345678;
    b32.pad_first_block = 1'b1;
    tick();
    idle_inputs();
    chk("w32_we_early", 32'(b32.core_write_enable), 32'd0);
    tick();
    chk("w32_we", 32'(b32.core_write_enable), 32'd1);
    chk("w32_data", b32.core_data, 32'h12345678);
    chk("w32_first", 32'(b32.core_first_block), 32'd1);
    tick();
    chk("w32_we_once", 32'(b32.core_write_enable), 32'd0);
    for (int i = 0; i < 8; i++) dw[i] = $urandom;
    got32.delete();
    n_hi = 0; first_hi = -1; last_hi = -1;
    for (int c = 0; c < 30; c++) begin
      b32.core_output_enable = (c < 8);
      b32.core_digest = (c < 8) ? dw[c] : $urandom;
      tick();
      if (b32.pad_output_enable) begin
        got32.push_back(b32.pad_digest);
        n_hi++;
        if (first_hi < 0) first_hi = c;
        last_hi = c;
      end
    end
    idle_inputs();
    chk("d32_oe_cycles", 32'(n_hi), 32'd8);
    chk("d32_contiguous", 32'(last_hi - first_hi + 1), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got32.size()) chk($sformatf("d32_word%0d", i), got32[i], dw[i]);
    end

    // Random inbound traffic: driver holds each beat until accepted, core stalls at random.
    for (int i = 0; i < 12; i++) begin
      rw[i] = $urandom;
      rf[i] = 1'($urandom_range(0, 1));
      rl[i] = 1'($urandom_range(0, 1));
    end
    rx = 0; wi = 0; bi = 0;
    for (int c = 0; c < 3000 && rx < 12; c++) begin
      b8.core_busy = ($urandom_range(0, 1) == 1);
      drive = (wi < 12) && ($urandom_range(0, 3) != 0);
      b8.pad_write_enable = drive;
      b8.pad_data = drive ? 8'((rw[wi] >> (24 - 8 * bi)) & 32'hff) : 8'($urandom);
      b8.pad_first_block = (drive && bi == 0) ? rf[wi] : 1'($urandom_range(0, 1));
      b8.pad_last_block  = (drive && bi == 0) ? rl[wi] : 1'($urandom_range(0, 1));
      accepted = drive && !b8.pad_busy;
      tick();
      if (accepted) begin
        bi++;
        if (bi == 4) begin
          bi = 0;
          wi++;
        end
      end
      if (b8.core_write_enable) begin
        if (rx < 12) begin
          chk($sformatf("rnd_data%0d", rx), b8.core_data, rw[rx]);
          chk($sformatf("rnd_first%0d", rx), 32'(b8.core_first_block), 32'(rf[rx]));
          chk($sformatf("rnd_last%0d", rx), 32'(b8.core_last_block), 32'(rl[rx]));
        end
        rx++;
      end
    end
    idle_inputs();
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (b8.core_write_enable) strobes++;
    end
    chk("rnd_word_count", 32'(rx), 32'd12);
    chk("rnd_no_extra", 32'(strobes), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sha256_pad_io_adapter.md
Name: sha256_pad_io_adapter

Overview:
Pin-reducing I/O adapter that sits between the pad ring and the SHA-256 core (`top`).
- Inbound: assembles narrow pad beats (PAD_W bits) into 32-bit message words and buffers them in a small FIFO. Words are forwarded to the core under its busy handshake.
- Outbound: captures the core's 32-bit digest words and re-serialises them as contiguous PAD_W-bit beats on the digest pads.
- It generalises the current fixed 32-bit pad interface to a configurable width, allowing package variants with fewer pins.

Parameters:
PAD_W, 8, pad data/digest width; legal values 8, 16, 32; BEATS = 32/PAD_W.
FIFO_DEPTH, 4, inbound word FIFO depth in 32-bit words; power of two, minimum 2.
DIGEST_WORDS, 8, number of 32-bit words in one digest.

Ports:
clk  input  1  single clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
pad_data  input  PAD_W  inbound message beat.
pad_write_enable  input  1  beat valid.
pad_first_block  input  1  first-block flag; sampled on beat 0 of each word.
pad_last_block  input  1  last-block flag; sampled on beat 0 of each word.
pad_busy  output  1  inbound FIFO full; beats are not accepted.
pad_digest  output  PAD_W  outbound digest beat.
pad_output_enable  output  1  pad_digest valid.
digest_overflow  output  1  sticky error: a digest word arrived with the buffer already holding DIGEST_WORDS words.
core_data  output  32  word to the core.
core_write_enable  output  1  one-cycle strobe per word.
core_first_block  output  1  flag travelling with core_data.
core_last_block  output  1  flag travelling with core_data.
core_busy  input  1  core cannot accept words.
core_digest  input  32  digest word from the core.
core_output_enable  input  1  core_digest valid.

Behaviour:
- Reset (synchronous, active-high, clk is the only clock):
  - All outputs are 0 after the reset edge.
  - FIFO is emptied and the beat counter cleared; partial words are discarded.
  - Any digest drain is aborted; digest_overflow is cleared.
  - Reset asserted mid-operation has the same effect. pad_output_enable is low from the first reset edge.
- Beat acceptance: a beat is accepted when pad_write_enable=1 and pad_busy=0. Beats offered while pad_busy=1 are ignored and the beat counter holds.
- Beat assembly:
  - Beat order is MSB-first: beat 0 lands in bits [31:32-PAD_W].
  - First/last flags are latched from beat 0.
  - The beat counter wraps 0..BEATS-1.
  - On the final beat, the assembled word plus flags is pushed into the FIFO at that edge.
- pad_busy = (fifo_count == FIFO_DEPTH), decoded from registered count. A final beat therefore always finds a free slot. A push and a pop on the same edge are legal; the count is unchanged.
- Forwarding (core_* outputs are registered):
  - At each edge, a word is popped and core_write_enable=1 is driven for the next cycle if all of the following hold: FIFO non-empty, core_busy=0, digest FSM in D_IDLE.
  - Otherwise core_write_enable=0 and core_data holds its last value.
  - Latency: final beat at edge k gives core_write_enable high in the cycle after edge k+1, with an idle, non-busy core.
  - At most one word is issued per cycle.
- Digest FSM: D_IDLE -> D_SEND -> D_IDLE.
  - Every edge with core_output_enable=1 writes core_digest into the digest buffer (DIGEST_WORDS entries) at the write pointer, in any state.
  - D_IDLE -> D_SEND on the first captured word.
  - In D_SEND, pad_output_enable=1 and pad_digest = the current word's beat, MSB-first. The beat counter advances every cycle; the word pointer advances after BEATS beats.
  - The output is contiguous: exactly DIGEST_WORDS*BEATS cycles high, with no gaps. Capture rate is at least send rate, so no underrun occurs.
  - After the last beat of word DIGEST_WORDS-1, go to D_IDLE. Pointers and the capture count clear, and pad_output_enable drops.
  - While in D_SEND, forwarding is stalled. Inbound beats continue to fill the FIFO.
  - A capture when the captured count is already DIGEST_WORDS is dropped, and digest_overflow is set to 1 (sticky until reset).
- Simultaneous capture and send of the same entry: the captured value is written before it is read for serialisation, so the first beat reflects the newly captured word.

Test Plan:
- PAD_W=8, core_busy=0: beats 0x61,0x62,0x63,0x80 on consecutive cycles with pad_first_block=1 on beat 0 -> core_data=0x61626380, core_first_block=1, core_write_enable high exactly one cycle, 2 cycles after the last beat edge.
- PAD_W=8: core_output_enable high for 8 consecutive cycles with SHA-256("abc") words 0xba7816bf,0x8f01cfea,... -> pad_output_enable high 32 contiguous cycles; pad_digest = ba,78,16,bf,8f,01,cf,ea,...,ad; then low; digest_overflow=0.
- core_busy=1, 4 full words pushed (FIFO_DEPTH=4) -> pad_busy=1; a 5th word's beats are ignored; release core_busy -> 4 strobes on consecutive cycles, pad_busy=0 after the first pop, 5th word absent.
- Reset asserted after 2 of 4 beats, then 4 new beats 0xDE,0xAD,0xBE,0xEF -> core_data=0xDEADBEEF (old partial word discarded); reset during D_SEND -> pad_output_enable=0 next cycle.
- 9 consecutive core_output_enable cycles -> 8 words serialised, digest_overflow=1 and held until reset.
- PAD_W=32: single beat 0x12345678 -> core_data=0x12345678 after 2 cycles; digest of 8 words -> pad_output_enable high exactly 8 cycles.
